// File: rtl/mac_pkg.sv
// mac_pkg: shared helpers for the multi-channel MAC.
// Signed saturating add and shift/round/saturate.
package mac_pkg;

  localparam int ST_EN    = 0;
  localparam int ST_BUSY  = 1;
  localparam int ST_MVAL  = 2;
  localparam int ST_STALL = 3;
  localparam int ST_OVF   = 4;

  typedef struct packed {
    logic        clip;
    logic [63:0] val;
  } sat_t;

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // clamp a wide signed value into w signed bits
  function automatic sat_t clamp(
    input logic signed [64:0] s,
    input int                 w
  );
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    sat_t               r;
    hi     = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo     = -hi - 65'sd1;
    r.clip = 1'b0;
    r.val  = s[63:0];
    if (s > hi) begin
      r.clip = 1'b1;
      r.val  = hi[63:0];
    end else if (s < lo) begin
      r.clip = 1'b1;
      r.val  = lo[63:0];
    end
    return r;
  endfunction

  function automatic sat_t sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 w
  );
    logic signed [64:0] s;
    s = $signed({a[63], a}) + $signed({b[63], b});
    return clamp(s, w);
  endfunction

  // round half up, arithmetic shift, then clamp
  function automatic sat_t round_shift_sat(
    input logic signed [63:0] a,
    input int                 sh,
    input int                 ow
  );
    logic signed [64:0] h;
    logic signed [64:0] s;
    h = (sh > 0) ? (65'sd1 <<< (sh - 1)) : 65'sd0;
    s = $signed({a[63], a}) + h;
    s = s >>> sh;
    return clamp(s, ow);
  endfunction

endpackage

// File: rtl/mac_round_sat.sv
// mac_round_sat: accumulator to narrow output word.
// Shift, round half up, saturate, report clipping.
module mac_round_sat
  import mac_pkg::*;
#(
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 24,
  parameter int OUT_SHIFT = 17
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic signed [OUT_WIDTH-1:0] data,
  output logic                        clip
);

  sat_t               r;
  logic signed [63:0] a64;
  logic               unused_hi;

  // widen, round and clamp in one pass
  always_comb begin
    a64  = 64'(acc);
    r    = round_shift_sat(a64, OUT_SHIFT, OUT_WIDTH);
    data = r.val[OUT_WIDTH-1:0];
    clip = r.clip;
  end

  assign unused_hi = ^r.val[63:OUT_WIDTH];

endmodule

// File: rtl/mac_unit_mc.sv
// mac_unit_mc: time-multiplexed signed MAC with a
// per-channel accumulator bank and rounded output.
module mac_unit_mc
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH      = 18,
  parameter int COEFF_WIDTH     = 18,
  parameter int ACC_WIDTH       = 48,
  parameter int NUM_CH          = 4,
  parameter int PIPELINE_STAGES = 3,
  parameter int OUT_WIDTH       = 24,
  parameter int OUT_SHIFT       = 17,
  localparam int CH_WIDTH       = ch_width(NUM_CH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic signed [DATA_WIDTH-1:0]  s_data,
  input  logic signed [COEFF_WIDTH-1:0] s_coeff,
  input  logic [CH_WIDTH-1:0]           s_ch,
  input  logic                          s_first,
  input  logic                          s_last,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic signed [ACC_WIDTH-1:0]   m_acc,
  output logic signed [OUT_WIDTH-1:0]   m_data,
  output logic [CH_WIDTH-1:0]           m_ch,
  output logic                          m_sat,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [15:0]                   status
);

  localparam int PW = DATA_WIDTH + COEFF_WIDTH;
  localparam int LS = PIPELINE_STAGES - 1;

  logic                 stall;
  logic                 adv;
  logic                 take;
  logic signed [PW-1:0] prod_in;

  logic signed [PW-1:0]       p_prod [PIPELINE_STAGES];
  logic [CH_WIDTH-1:0]        p_ch   [PIPELINE_STAGES];
  logic [PIPELINE_STAGES-1:0] p_first;
  logic [PIPELINE_STAGES-1:0] p_last;
  logic [PIPELINE_STAGES-1:0] p_valid;

  logic signed [ACC_WIDTH-1:0] bank [NUM_CH];
  logic [NUM_CH-1:0]           ovf;

  logic [CH_WIDTH-1:0]         t_ch;
  logic signed [ACC_WIDTH-1:0] t_prod;
  logic signed [ACC_WIDTH-1:0] t_cur;
  logic signed [ACC_WIDTH-1:0] nacc;
  logic                        novf;
  logic                        fire;
  sat_t                        sa;
  logic signed [OUT_WIDTH-1:0] r_data;
  logic                        r_clip;
  logic                        unused_hi;

  assign stall   = m_valid && !m_ready;
  assign adv     = enable && !stall;
  assign s_ready = adv && !rst;
  assign take    = s_valid && s_ready &&
                   (int'(s_ch) < NUM_CH);
  assign prod_in = PW'(s_data) * PW'(s_coeff);

  // product pipeline: stage 0 captures, rest shift
  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid <= '0;
      p_first <= '0;
      p_last  <= '0;
      for (int i = 0; i < PIPELINE_STAGES; i++) begin
        p_prod[i] <= '0;
        p_ch[i]   <= '0;
      end
    end else if (adv) begin
      p_valid[0] <= take;
      p_first[0] <= s_first;
      p_last[0]  <= s_last;
      p_prod[0]  <= prod_in;
      p_ch[0]    <= s_ch;
      for (int i = 1; i < PIPELINE_STAGES; i++) begin
        p_valid[i] <= p_valid[i-1];
        p_first[i] <= p_first[i-1];
        p_last[i]  <= p_last[i-1];
        p_prod[i]  <= p_prod[i-1];
        p_ch[i]    <= p_ch[i-1];
      end
    end
  end

  assign t_ch   = p_ch[LS];
  assign fire   = adv && p_valid[LS];
  assign t_prod = ACC_WIDTH'(p_prod[LS]);
  assign t_cur  = bank[t_ch];

  // next accumulator value and sticky overflow
  always_comb begin
    sa = sat_add(64'(t_cur), 64'(t_prod), ACC_WIDTH);
    if (p_first[LS]) begin
      nacc = t_prod;
      novf = 1'b0;
    end else begin
      nacc = sa.val[ACC_WIDTH-1:0];
      novf = ovf[t_ch] | sa.clip;
    end
  end

  assign unused_hi = ^sa.val[63:ACC_WIDTH];

  // single-writer update of the addressed channel
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        bank[i] <= '0;
      end
    end else if (fire) begin
      bank[t_ch] <= nacc;
      ovf[t_ch]  <= novf;
    end
  end

  mac_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_rs (
    .acc  (nacc),
    .data (r_data),
    .clip (r_clip)
  );

  // output register: load on last beat, clear on take
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_acc   <= '0;
      m_data  <= '0;
      m_ch    <= '0;
      m_sat   <= 1'b0;
    end else if (fire && p_last[LS]) begin
      m_valid <= 1'b1;
      m_acc   <= nacc;
      m_data  <= r_data;
      m_ch    <= t_ch;
      m_sat   <= novf | r_clip;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // status word
  always_comb begin
    status                = '0;
    status[ST_EN]         = enable;
    status[ST_BUSY]       = |p_valid;
    status[ST_MVAL]       = m_valid;
    status[ST_STALL]      = stall;
    status[ST_OVF +: 8]   = 8'(ovf);
  end

endmodule

// File: tb/tb_mac_unit_mc.sv
// tb_mac_unit_mc: directed bench with an arithmetic
// model for a default and a narrow-accumulator instance.
module tb_mac_unit_mc;

  typedef struct {
    longint acc0;
    longint acc1;
    longint dat0;
    longint dat1;
    bit     sat0;
    bit     sat1;
    int     ch;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic signed [17:0] s_data;
  logic signed [17:0] s_coeff;
  logic [1:0] s_ch;
  logic s_first;
  logic s_last;
  logic s_valid;
  logic m_ready;

  logic a_ready, b_ready;
  logic signed [47:0] a_acc;
  logic signed [35:0] b_acc;
  logic signed [23:0] a_data, b_data;
  logic [1:0] a_ch, b_ch;
  logic a_sat, b_sat, a_valid, b_valid;
  logic [15:0] a_status, b_status;

  int total = 0;
  int bad = 0;

  exp_t q[$];
  bit seen = 0;
  longint mb[2][4];
  bit mo[2][4];
  int AW[2] = '{48, 36};
  int SH[2] = '{17, 2};

  longint lg_acc_a[$];
  longint lg_acc_b[$];
  longint lg_dat_b[$];
  longint lg_sat_b[$];
  longint lg_ch[$];

  always #5 clk = ~clk;

  mac_unit_mc u_a (
    .clk(clk), .rst(rst), .enable(enable),
    .s_data(s_data), .s_coeff(s_coeff),
    .s_ch(s_ch), .s_first(s_first),
    .s_last(s_last), .s_valid(s_valid),
    .s_ready(a_ready), .m_acc(a_acc),
    .m_data(a_data), .m_ch(a_ch),
    .m_sat(a_sat), .m_valid(a_valid),
    .m_ready(m_ready), .status(a_status)
  );

  mac_unit_mc #(
    .ACC_WIDTH(36), .OUT_SHIFT(2)
  ) u_b (
    .clk(clk), .rst(rst), .enable(enable),
    .s_data(s_data), .s_coeff(s_coeff),
    .s_ch(s_ch), .s_first(s_first),
    .s_last(s_last), .s_valid(s_valid),
    .s_ready(b_ready), .m_acc(b_acc),
    .m_data(b_data), .m_ch(b_ch),
    .m_sat(b_sat), .m_valid(b_valid),
    .m_ready(m_ready), .status(b_status)
  );

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic longint lv(input longint qq[$],
                                input int i);
    if (i < qq.size()) return qq[i];
    return -12345;
  endfunction

  function automatic longint clampw(input longint v,
                                    input int w,
                                    output bit c);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    c = 1'b0;
    if (v > hi) begin c = 1'b1; return hi; end
    if (v < lo) begin c = 1'b1; return lo; end
    return v;
  endfunction

  // result of an accepted beat: update channel sums now
  task automatic model_accept();
    longint p, s, r, acc[2], dat[2];
    bit c, rc, st[2];
    int ch;
    exp_t e;
    p = longint'(s_data) * longint'(s_coeff);
    ch = int'(s_ch);
    for (int i = 0; i < 2; i++) begin
      if (s_first) begin
        mb[i][ch] = p;
        mo[i][ch] = 1'b0;
      end else begin
        s = clampw(mb[i][ch] + p, AW[i], c);
        mb[i][ch] = s;
        mo[i][ch] = mo[i][ch] | c;
      end
      r = mb[i][ch];
      if (SH[i] > 0) r = r + (longint'(1) << (SH[i] - 1));
      r = r >>> SH[i];
      dat[i] = clampw(r, 24, rc);
      acc[i] = mb[i][ch];
      st[i] = mo[i][ch] | rc;
    end
    if (s_last) begin
      e.acc0 = acc[0]; e.acc1 = acc[1];
      e.dat0 = dat[0]; e.dat1 = dat[1];
      e.sat0 = st[0];  e.sat1 = st[1];
      e.ch = ch;
      q.push_back(e);
    end
  endtask

  // compare outputs each cycle, then track inputs
  always @(negedge clk) begin
    exp_t e;
    if (a_valid || b_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious: got valid expected idle");
      end else begin
        e = q[0];
        chk("a_valid", longint'(a_valid), 1);
        chk("b_valid", longint'(b_valid), 1);
        chk("a_acc", longint'(a_acc), e.acc0);
        chk("b_acc", longint'(b_acc), e.acc1);
        chk("a_data", longint'(a_data), e.dat0);
        chk("b_data", longint'(b_data), e.dat1);
        chk("a_sat", longint'(a_sat), longint'(e.sat0));
        chk("b_sat", longint'(b_sat), longint'(e.sat1));
        chk("a_ch", longint'(a_ch), longint'(e.ch));
        chk("b_ch", longint'(b_ch), longint'(e.ch));
        if (!seen) begin
          lg_acc_a.push_back(longint'(a_acc));
          lg_acc_b.push_back(longint'(b_acc));
          lg_dat_b.push_back(longint'(b_data));
          lg_sat_b.push_back(longint'(b_sat));
          lg_ch.push_back(longint'(a_ch));
          seen = 1'b1;
        end
        if (m_ready && !rst) begin
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
    if (rst) begin
      q.delete();
      seen = 1'b0;
      for (int i = 0; i < 2; i++)
        for (int c = 0; c < 4; c++) begin
          mb[i][c] = 0;
          mo[i][c] = 1'b0;
        end
    end else if (s_valid && a_ready) begin
      model_accept();
    end
  end

  task automatic clr_log();
    lg_acc_a.delete(); lg_acc_b.delete();
    lg_dat_b.delete(); lg_sat_b.delete();
    lg_ch.delete();
  endtask

  task automatic send(input int ch, input int d,
                      input int c, input bit f,
                      input bit l);
    int n;
    bit ok;
    s_ch = 2'(ch);
    s_data = 18'(d);
    s_coeff = 18'(c);
    s_first = f;
    s_last = l;
    s_valid = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = a_ready;
      n++;
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || a_status[1]) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_q", q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; enable = 1'b1; m_ready = 1'b1;
    s_valid = 1'b0; s_data = '0; s_coeff = '0;
    s_ch = '0; s_first = 1'b0; s_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_valid", longint'(a_valid), 0);
    chk("rst_b_valid", longint'(b_valid), 0);
    chk("rst_a_acc", longint'(a_acc), 0);
    chk("rst_ready", longint'(a_ready), 0);
    chk("rst_status", longint'(a_status), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_on", longint'(a_ready), 1);

    // single-channel dot product and latency
    for (int b = 0; b < 4; b++) send(0, 3, -2, b == 0, b == 3);
    n = 0;
    while (!a_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, 3);
    chk("t1_acc", longint'(a_acc), -24);
    chk("t1_data", longint'(a_data), 0);
    drain();

    // interleaved channels
    clr_log();
    for (int b = 0; b < 8; b++)
      for (int c = 0; c < 4; c++)
        send(c, c + 1, 1000, b == 0, b == 7);
    drain();
    chk("il_count", lg_acc_a.size(), 4);
    for (int c = 0; c < 4; c++) begin
      chk("il_ch", lv(lg_ch, c), c);
      chk("il_acc", lv(lg_acc_a, c), 8000 * (c + 1));
    end

    // backpressure
    clr_log();
    m_ready = 1'b0;
    for (int c = 0; c < 4; c++) send(c, 100 * (c + 1), 7, 1, 1);
    for (int k = 0; k < 10; k++) begin
      chk("bp_ready", longint'(a_ready), 0);
      chk("bp_stall", longint'(a_status[3]), 1);
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    drain();
    chk("bp_count", lg_acc_a.size(), 4);
    for (int c = 0; c < 4; c++)
      chk("bp_acc", lv(lg_acc_a, c), 700 * (c + 1));

    // accumulator saturation on the narrow instance
    clr_log();
    send(1, -131072, -131072, 1, 0);
    send(1, -131072, -131072, 0, 0);
    send(1, -131072, -131072, 0, 1);
    drain();
    chk("sat_acc_b", lv(lg_acc_b, 0), 64'sd34359738367);
    chk("sat_flag_b", lv(lg_sat_b, 0), 1);
    chk("sat_acc_a", lv(lg_acc_a, 0), 64'sd51539607552);
    chk("sat_st_b", longint'(b_status[5]), 1);
    chk("sat_st_a", longint'(a_status[5]), 0);
    send(1, 1, 1, 1, 1);
    drain();
    chk("sat_clr_b", longint'(b_status[5]), 0);

    // rounding and output saturation
    clr_log();
    send(2, 3, 2, 1, 1);
    send(2, -3, 2, 1, 1);
    send(3, -131072, -131072, 1, 1);
    drain();
    chk("rnd_pos", lv(lg_dat_b, 0), 2);
    chk("rnd_neg", lv(lg_dat_b, 1), -1);
    chk("rnd_big", lv(lg_dat_b, 2), 8388607);
    chk("rnd_sat0", lv(lg_sat_b, 0), 0);
    chk("rnd_sat2", lv(lg_sat_b, 2), 1);

    // freeze and resume
    clr_log();
    send(0, 10, 10, 1, 0);
    send(0, 10, 10, 0, 1);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("en_ready", longint'(a_ready), 0);
      chk("en_hold", longint'(a_valid), 0);
    end
    chk("en_busy", longint'(a_status[1]), 1);
    enable = 1'b1;
    drain();
    chk("en_acc", lv(lg_acc_a, 0), 200);

    // reset with beats in flight
    send(0, 1, 1, 1, 1);
    send(1, 2, 1, 1, 1);
    send(2, 3, 1, 1, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_a_valid", longint'(a_valid), 0);
    chk("mr_b_valid", longint'(b_valid), 0);
    chk("mr_busy", longint'(a_status[1]), 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mr_idle", longint'(a_valid), 0);
    clr_log();
    send(0, 5, 7, 1, 0);
    send(0, -1, 3, 0, 1);
    drain();
    chk("mr_acc", lv(lg_acc_a, 0), 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
